// File: rtl/fib_readback_checker_pkg.sv
// Shared memory-test definitions: bus widths and the readback checker FSM encoding.
package fib_readback_checker_pkg;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/fib_readback_checker_fib_gen.sv
// Incremental Fibonacci source: value is fib(k), advance steps k by one, clear restarts at k=0.
module fib_gen
  import fib_readback_checker_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [DATA_W-1:0] value
);
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;

  // a_q holds fib(k) and b_q holds fib(k+1); the sum wraps mod 2^DATA_W
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      a_q <= '0;
      b_q <= DATA_W'(1);
    end else if (advance) begin
      a_q <= b_q;
      b_q <= a_q + b_q;
    end
  end

  assign value = a_q;
endmodule

// File: rtl/fib_readback_checker.sv
// Reads NUM_ENTRIES words at k*STRIDE over memory port B and compares each with fib(k).
module fib_readback_checker
  import fib_readback_checker_pkg::*;
#(
  parameter int NUM_ENTRIES = 17,
  parameter int STRIDE      = 1024,
  parameter int READ_LAT    = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              enB,
  output logic [ADDR_W-1:0] AddressB,
  input  logic [DATA_W-1:0] DoutB,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);
  localparam int K_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int L_W = $clog2(READ_LAT + 1);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
  localparam logic [K_W-1:0]    LAST_K   = K_W'(NUM_ENTRIES - 1);
  localparam logic [L_W-1:0]    LAST_W   = L_W'(READ_LAT - 1);

  state_e            state_q;
  logic [K_W-1:0]    k_q;
  logic [L_W-1:0]    wait_q;
  logic              enB_q;
  logic [ADDR_W-1:0] addr_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [7:0]        err_q;
  logic [7:0]        err_d;
  logic [ADDR_W-1:0] fea_q;
  logic [DATA_W-1:0] fed_q;
  logic [DATA_W-1:0] fib_value;
  logic              start_ok;
  logic              mismatch;

  // A start is only honoured between runs; mid-run pulses fall through
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
  assign mismatch = (DoutB != fib_value);
  assign err_d    = (mismatch && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;

  fib_gen u_fib (
    .clock   (clock),
    .reset   (reset),
    .clear   (start_ok),
    .advance (state_q == CHECK),
    .value   (fib_value)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      wait_q  <= '0;
      enB_q   <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fea_q   <= '0;
      fed_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= ISSUE;
            k_q     <= '0;
            enB_q   <= 1'b1;
            addr_q  <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fea_q   <= '0;
            fed_q   <= '0;
          end
        end
        ISSUE: begin
          enB_q   <= 1'b0;
          wait_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (wait_q == LAST_W) state_q <= CHECK;
          else                  wait_q  <= wait_q + L_W'(1);
        end
        CHECK: begin
          err_q <= err_d;
          // err_q never returns to zero within a run, so zero marks the first miss
          if (mismatch && (err_q == 8'd0)) begin
            fea_q <= addr_q;
            fed_q <= DoutB;
          end
          if (k_q == LAST_K) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 8'd0);
          end else begin
            state_q <= ISSUE;
            k_q     <= k_q + K_W'(1);
            addr_q  <= addr_q + STRIDE_A;
            enB_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign enB            = enB_q;
  assign AddressB       = addr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = fea_q;
  assign first_err_data = fed_q;
endmodule

// File: tb/tb_fib_readback_checker.sv
// Directed bench: latency-1 and latency-2 checkers reading a shared memory preloaded with fib(k).
module tb_fib_readback_checker;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic sel   = 1'b0;

  always #5 clock = ~clock;

  logic        start1, start2;
  logic        e1, e2, b1, b2, d1, d2, p1, p2;
  logic [14:0] a1, a2, fa1, fa2;
  logic [15:0] dout1, dout2, fd1, fd2;
  logic [7:0]  ec1, ec2;

  assign start1 = start & ~sel;
  assign start2 = start & sel;

  fib_readback_checker u_dut1 (
    .clock(clock), .reset(reset), .start(start1), .enB(e1), .AddressB(a1), .DoutB(dout1),
    .busy(b1), .done(d1), .pass(p1), .err_count(ec1), .first_err_addr(fa1), .first_err_data(fd1)
  );

  fib_readback_checker #(.READ_LAT(2)) u_dut2 (
    .clock(clock), .reset(reset), .start(start2), .enB(e2), .AddressB(a2), .DoutB(dout2),
    .busy(b2), .done(d2), .pass(p2), .err_count(ec2), .first_err_addr(fa2), .first_err_data(fd2)
  );

  logic        en_s, busy_s, done_s, pass_s;
  logic [14:0] addr_s, fea_s;
  logic [15:0] fed_s;
  logic [7:0]  err_s;
  assign en_s   = sel ? e2  : e1;
  assign addr_s = sel ? a2  : a1;
  assign busy_s = sel ? b2  : b1;
  assign done_s = sel ? d2  : d1;
  assign pass_s = sel ? p2  : p1;
  assign err_s  = sel ? ec2 : ec1;
  assign fea_s  = sel ? fa2 : fa1;
  assign fed_s  = sel ? fd2 : fd1;

  // Memory model: one read register, plus an extra stage for the latency-2 port
  logic [15:0] mem [0:32767];
  logic [15:0] r1, r2a, r2b;
  always @(posedge clock) begin
    if (e1) r1 <= mem[a1];
    if (e2) r2a <= mem[a2];
    r2b <= r2a;
  end
  assign dout1 = r1;
  assign dout2 = r2b;

  logic [15:0] fib_tab [0:16] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13,
                                  16'd21, 16'd34, 16'd55, 16'd89, 16'd144, 16'd233,
                                  16'd377, 16'd610, 16'd987};

  int n_chk = 0;
  int n_bad = 0;
  int r_cyc, r_en, r_addr_bad, r_busy_bad;
  logic r_done_clr;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic preload();
    for (int k = 0; k < 17; k++) mem[k*1024] = fib_tab[k];
  endtask

  // Called #1 after a rising edge; pulses start and follows the run until done.
  task automatic do_run(input int restart_at);
    r_cyc = -1; r_en = 0; r_addr_bad = 0; r_busy_bad = 0; r_done_clr = 1'b1;
    start = 1'b1;
    for (int i = 0; i <= 200; i++) begin
      @(posedge clock); #1;
      start = (i + 1 == restart_at);
      if (i == 0) r_done_clr = done_s;
      if (done_s) begin
        r_cyc = i;
        break;
      end
      if (!busy_s) r_busy_bad++;
      if (en_s) begin
        if (addr_s !== 15'(r_en * 1024)) r_addr_bad++;
        r_en++;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_good_run(input string tag, input int exp_cyc);
    check_val({tag, "_cycles"}, r_cyc, exp_cyc);
    check_val({tag, "_enb_pulses"}, r_en, 17);
    check_val({tag, "_addr_errs"}, r_addr_bad, 0);
    check_val({tag, "_busy_gaps"}, r_busy_bad, 0);
    check_val({tag, "_done_cleared"}, r_done_clr, 0);
    check_val({tag, "_pass"}, pass_s, 1);
    check_val({tag, "_err_count"}, err_s, 0);
    check_val({tag, "_busy_at_done"}, busy_s, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int done_seen;
    for (int i = 0; i < 32768; i++) mem[i] = 16'hFFFF;
    preload();

    repeat (3) @(posedge clock);
    #1;
    check_val("rst_enb", e1, 0);
    check_val("rst_addr", a1, 0);
    check_val("rst_busy", b1, 0);
    check_val("rst_done", d1, 0);
    check_val("rst_pass", p1, 0);
    check_val("rst_err", ec1, 0);
    check_val("rst_fea", fa1, 0);
    check_val("rst_fed", fd1, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    do_run(0);
    check_good_run("clean", 51);

    mem[5120] = 16'h0000;
    do_run(0);
    check_val("one_err_cycles", r_cyc, 51);
    check_val("one_err_pass", pass_s, 0);
    check_val("one_err_count", err_s, 1);
    check_val("one_err_fea", fea_s, 15'd5120);
    check_val("one_err_fed", fed_s, 16'h0000);

    preload();
    mem[3072] = 16'h1234;
    mem[9216] = 16'h0000;
    do_run(0);
    check_val("two_err_pass", pass_s, 0);
    check_val("two_err_count", err_s, 2);
    check_val("two_err_fea", fea_s, 15'd3072);
    check_val("two_err_fed", fed_s, 16'h1234);

    preload();
    do_run(20);
    check_good_run("restart_mid", 51);
    do_run(0);
    check_good_run("restart_done", 51);

    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    check_val("midrst_enb", e1, 0);
    check_val("midrst_addr", a1, 0);
    check_val("midrst_busy", b1, 0);
    check_val("midrst_done", d1, 0);
    check_val("midrst_pass", p1, 0);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clock); #1;
      if (d1) done_seen++;
    end
    check_val("midrst_no_done", done_seen, 0);
    do_run(0);
    check_good_run("after_rst", 51);

    sel = 1'b1;
    do_run(0);
    check_good_run("lat2", 68);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/fib_readback_checker.md
FIB_READBACK_CHECKER -- requirements
Module: fib_readback_checker

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 17, giving the number of locations read and checked per run.
REQ-002 SHALL have parameter STRIDE, default 1024, giving the address spacing between consecutive entries.
REQ-003 SHALL have parameter READ_LAT, default 1, giving the port-B cycles from the enB cycle to valid DoutB.
REQ-004 SHALL have port clock, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, a one-cycle request that begins a readback run.
REQ-007 SHALL have port enB, output, 1, the port-B read enable.
REQ-008 SHALL have port AddressB, output, 15, the port-B read address.
REQ-009 SHALL have port DoutB, input, 16, the port-B read data.
REQ-010 SHALL have port busy, output, 1, high while a run is in progress.
REQ-011 SHALL have port done, output, 1, high from run completion until the next start or reset.
REQ-012 SHALL have port pass, output, 1, valid when done is high; 1 means no mismatches occurred.
REQ-013 SHALL have port err_count, output, 8, the number of mismatches in the run; saturates at 255.
REQ-014 SHALL have ports first_err_addr, output, 15, and first_err_data, output, 16, giving the address and read data of the first mismatch.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, CHECK and DONE.
REQ-016 IDLE SHALL move to ISSUE when start=1; DONE SHALL move to ISSUE when start=1, clearing done, pass, err_count and the first_err registers.
REQ-017 A start that arrives in ISSUE, WAIT or CHECK SHALL be ignored.
REQ-018 ISSUE SHALL drive enB=1 and AddressB=(k*STRIDE) mod 2^15 for exactly one cycle, where k is the entry index starting at 0.
REQ-019 WAIT SHALL last exactly READ_LAT cycles with enB=0; CHECK SHALL last one cycle and sample DoutB.
REQ-020 The expected value SHALL be fib(k) mod 2^16, where fib(0)=0 and fib(1)=1.
REQ-021 The expected value SHALL be generated incrementally by a two-register adder advanced in CHECK, with no lookup table.
REQ-022 On a mismatch in CHECK, err_count SHALL increment (saturating), and on the first mismatch of the run first_err_addr and first_err_data SHALL be captured.
REQ-023 After CHECK of entry NUM_ENTRIES-1 the FSM SHALL enter DONE, with done=1 and pass=(err_count==0); otherwise it SHALL return to ISSUE with k+1.
REQ-024 Each entry SHALL take 2+READ_LAT cycles; with the defaults, done SHALL rise 51 cycles after the cycle in which start is sampled.
REQ-025 busy SHALL equal 1 in ISSUE, WAIT and CHECK, and 0 otherwise.
REQ-026 enB SHALL never be high outside ISSUE.
REQ-027 The address multiply SHALL wrap modulo 2^15 with no error flag.

Reset
REQ-028 While reset=1 the FSM SHALL be in IDLE, and enB, AddressB, busy, done, pass, err_count, first_err_addr, first_err_data and k SHALL all be 0.
REQ-029 The Fibonacci registers SHALL reset to the pair (0,1).
REQ-030 Reset asserted mid-run SHALL abort the run on the next edge without asserting done, and a later start SHALL begin again at k=0.
REQ-031 Reset SHALL take priority over start in the same cycle.

Structure
REQ-032 The FSM state encoding and the ADDR_W=15 and DATA_W=16 constants SHALL live in the shared processor memory-test package.
REQ-033 The Fibonacci generator SHALL be one sub-module, fib_gen, with ports clock, reset, clear, advance and value.
REQ-034 All other logic SHALL be flat within fib_readback_checker.

Verification
REQ-035 Preload memory with fib(k) at k*1024 for k=0..16, pulse start -> 17 enB pulses at addresses 0, 1024, ..., 16384; done at cycle 51; pass=1; err_count=0.
REQ-036 Preload as REQ-035 but with 0x0000 at 5120 -> pass=0, err_count=1, first_err_addr=5120, first_err_data=0x0000.
REQ-037 Corrupt entries 3 and 9 -> err_count=2, first_err_addr=3072.
REQ-038 Pulse start again at cycle 20 of a run -> the run is unaffected and done rises at cycle 51; a start pulse in DONE -> done clears and a second identical run follows.
REQ-039 Assert reset at cycle 10 of a run -> all outputs are 0 next cycle and done never rises; a new start gives a full correct run.
REQ-040 With READ_LAT=2 -> each entry takes 4 cycles and done rises at cycle 68 with pass=1.
